// File: rtl/text_console_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_ctrl_if
//  Description : Character-stream handshake, cursor status and display-RAM
//                CPU-port signals of the text console controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_console_ctrl_if #(
   parameter int RAM_WIDTH     = 7,
   parameter int RAM_ADDR_BITS = 8
);
   logic [RAM_WIDTH-1:0]     charIn;
   logic                     charValid;
   logic                     charReady;
   logic                     clearReq;
   logic                     busy;
   logic [RAM_ADDR_BITS-1:0] cursorCol;
   logic [RAM_ADDR_BITS-2:0] cursorRow;
   logic                     ramWriteEn;
   logic [RAM_WIDTH-1:0]     ramWriteData;
   logic [RAM_ADDR_BITS-1:0] ramHGlyph;
   logic [RAM_ADDR_BITS-2:0] ramVGlyph;

   // Character source / system side
   modport master (
      output charIn, charValid, clearReq,
      input  charReady, busy, cursorCol, cursorRow,
             ramWriteEn, ramWriteData, ramHGlyph, ramVGlyph
   );

   // Controller side
   modport slave (
      input  charIn, charValid, clearReq,
      output charReady, busy, cursorCol, cursorRow,
             ramWriteEn, ramWriteData, ramHGlyph, ramVGlyph
   );
endinterface
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : text_console_ctrl
//  Description : Sequences character-display RAM writes from a stream of
//                character codes: printable glyphs, LF/CR/BS/FF control
//                codes, line wrap with line clear, and full-screen clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_console_ctrl #(
   parameter int                   RAM_WIDTH     = 7,
   parameter int                   RAM_ADDR_BITS = 8,
   parameter int                   COLS          = 80,
   parameter int                   ROWS          = 60,
   parameter logic [RAM_WIDTH-1:0] BLANK         = 7'h20
) (
   input  wire logic          clk,
   input  wire logic          reset,
   text_console_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      CLR_LINE = 2'd2,
      CLR_ALL  = 2'd3
   } state_t;

   localparam logic [RAM_ADDR_BITS-1:0] COL_LAST = RAM_ADDR_BITS'(COLS - 1);
   localparam logic [RAM_ADDR_BITS-1:0] COL_STEP = RAM_ADDR_BITS'(1);
   localparam logic [RAM_ADDR_BITS-2:0] ROW_LAST = (RAM_ADDR_BITS-1)'(ROWS - 1);
   localparam logic [RAM_ADDR_BITS-2:0] ROW_STEP = (RAM_ADDR_BITS-1)'(1);

   localparam logic [RAM_WIDTH-1:0] CODE_BS = RAM_WIDTH'('h08);
   localparam logic [RAM_WIDTH-1:0] CODE_LF = RAM_WIDTH'('h0A);
   localparam logic [RAM_WIDTH-1:0] CODE_FF = RAM_WIDTH'('h0C);
   localparam logic [RAM_WIDTH-1:0] CODE_CR = RAM_WIDTH'('h0D);
   localparam logic [RAM_WIDTH-1:0] CODE_LO = RAM_WIDTH'('h20);
   localparam logic [RAM_WIDTH-1:0] CODE_HI = RAM_WIDTH'('h7E);

   state_t                   state;
   logic [RAM_WIDTH-1:0]     char_lat;
   logic [RAM_ADDR_BITS-1:0] col;
   logic [RAM_ADDR_BITS-2:0] row;
   logic                     write_en;
   logic [RAM_WIDTH-1:0]     write_data;
   logic [RAM_ADDR_BITS-1:0] h_glyph;
   logic [RAM_ADDR_BITS-2:0] v_glyph;

   logic                     in_printable;
   logic                     lat_printable;
   logic                     row_adv;
   logic [RAM_ADDR_BITS-2:0] next_row;

   function automatic logic is_printable(input logic [RAM_WIDTH-1:0] code);
      return (code >= CODE_LO) && (code <= CODE_HI);
   endfunction

   // clearReq outranks a coincident character, so it also gates ready
   assign bus.charReady = (state == IDLE) && !bus.clearReq;
   assign bus.busy      = (state != IDLE);

   assign bus.cursorCol    = col;
   assign bus.cursorRow    = row;
   assign bus.ramWriteEn   = write_en;
   assign bus.ramWriteData = write_data;
   assign bus.ramHGlyph    = h_glyph;
   assign bus.ramVGlyph    = v_glyph;

   assign in_printable  = is_printable(bus.charIn);
   assign lat_printable = is_printable(char_lat);
   // Wrapping past the last column behaves exactly like a line feed
   assign row_adv       = (lat_printable && (col == COL_LAST)) || (char_lat == CODE_LF);
   assign next_row      = (row == ROW_LAST) ? '0 : row + ROW_STEP;

   // Controller FSM; RAM write strobe/address/data are set up one edge ahead
   // so they are valid for the whole cycle the RAM captures them in
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         char_lat   <= '0;
         col        <= '0;
         row        <= '0;
         write_en   <= 1'b0;
         write_data <= '0;
         h_glyph    <= '0;
         v_glyph    <= '0;
      end else begin
         case (state)
            IDLE: begin
               write_en <= 1'b0;
               if (bus.clearReq) begin
                  state      <= CLR_ALL;
                  write_en   <= 1'b1;
                  write_data <= BLANK;
                  h_glyph    <= '0;
                  v_glyph    <= '0;
               end else if (bus.charValid) begin
                  // Accept: the glyph write for this code happens in WRITE
                  char_lat <= bus.charIn;
                  state    <= WRITE;
                  if (in_printable) begin
                     write_en   <= 1'b1;
                     write_data <= bus.charIn;
                     h_glyph    <= col;
                     v_glyph    <= row;
                  end else if ((bus.charIn == CODE_BS) && (col != '0)) begin
                     write_en   <= 1'b1;
                     write_data <= BLANK;
                     h_glyph    <= col - COL_STEP;
                     v_glyph    <= row;
                  end
               end
            end

            WRITE: begin
               write_en <= 1'b0;
               state    <= IDLE;
               if (row_adv) begin
                  // New line: cursor to column 0 and blank the whole new row
                  col        <= '0;
                  row        <= next_row;
                  state      <= CLR_LINE;
                  write_en   <= 1'b1;
                  write_data <= BLANK;
                  h_glyph    <= '0;
                  v_glyph    <= next_row;
               end else if (lat_printable) begin
                  col <= col + COL_STEP;
               end else begin
                  case (char_lat)
                     CODE_CR: col <= '0;
                     CODE_BS: begin
                        if (col != '0) col <= col - COL_STEP;
                     end
                     CODE_FF: begin
                        state      <= CLR_ALL;
                        write_en   <= 1'b1;
                        write_data <= BLANK;
                        h_glyph    <= '0;
                        v_glyph    <= '0;
                     end
                     default: ;
                  endcase
               end
            end

            CLR_LINE: begin
               if (h_glyph == COL_LAST) begin
                  write_en <= 1'b0;
                  state    <= IDLE;
               end else begin
                  h_glyph <= h_glyph + COL_STEP;
               end
            end

            CLR_ALL: begin
               if (h_glyph == COL_LAST) begin
                  if (v_glyph == ROW_LAST) begin
                     write_en <= 1'b0;
                     state    <= IDLE;
                     col      <= '0;
                     row      <= '0;
                  end else begin
                     h_glyph <= '0;
                     v_glyph <= v_glyph + ROW_STEP;
                  end
               end else begin
                  h_glyph <= h_glyph + COL_STEP;
               end
            end

            default: begin
               write_en <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_console_ctrl
//  Description : Self-checking bench for text_console_ctrl. Expected RAM
//                writes are queued as stimulus is issued; a monitor pops and
//                compares each write the controller presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_ctrl;

   localparam int COLS = 80;
   localparam int ROWS = 60;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   text_console_ctrl_if bus ();

   text_console_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int h;
      int v;
      int d;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;
   int  n;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push_wr(input int h, input int v, input int d);
      sb.push_back('{h, v, d});
   endtask

   task automatic push_line(input int v);
      for (int h = 0; h < COLS; h++) push_wr(h, v, 'h20);
   endtask

   task automatic push_screen(input int cnt);
      for (int i = 0; i < cnt; i++) push_wr(i % COLS, i / COLS, 'h20);
   endtask

   // Present a code and hold it until the edge that accepts it;
   // returns at accept edge + 1 time unit (inside the WRITE cycle)
   task automatic send(input int code);
      int waited;
      bus.charIn    = 7'(code);
      bus.charValid = 1'b1;
      waited = 0;
      while (!bus.charReady && waited < 10000) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 10000) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=not_ready required=ready code=%0h", code);
      end
      @(posedge clk); #1;
      bus.charValid = 1'b0;
   endtask

   // Number of sampled cycles (one per clock) with busy high
   task automatic busy_count(output int cnt);
      cnt = 0;
      while (bus.busy && cnt < 10000) begin
         cnt++;
         @(posedge clk); #1;
      end
      if (cnt >= 10000) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout actual=busy required=idle");
      end
   endtask

   // Write monitor: every presented write must match the queue head
   initial begin
      forever begin
         @(negedge clk);
         if (bus.ramWriteEn === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write actual H=%0d V=%0d data=%0h required no write",
                        bus.ramHGlyph, bus.ramVGlyph, bus.ramWriteData);
            end else begin
               mon_e = sb.pop_front();
               if (int'(bus.ramHGlyph) !== mon_e.h || int'(bus.ramVGlyph) !== mon_e.v ||
                   int'(bus.ramWriteData) !== mon_e.d) begin
                  errors++;
                  $display("FAIL ram_write actual H=%0d V=%0d data=%0h required H=%0d V=%0d data=%0h",
                           bus.ramHGlyph, bus.ramVGlyph, bus.ramWriteData,
                           mon_e.h, mon_e.v, mon_e.d);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      reset         = 1'b1;
      bus.charIn    = '0;
      bus.charValid = 1'b0;
      bus.clearReq  = 1'b0;
      #12;
      chk("rst_we",    int'(bus.ramWriteEn), 0);
      chk("rst_data",  int'(bus.ramWriteData), 0);
      chk("rst_h",     int'(bus.ramHGlyph), 0);
      chk("rst_v",     int'(bus.ramVGlyph), 0);
      chk("rst_busy",  int'(bus.busy), 0);
      chk("rst_col",   int'(bus.cursorCol), 0);
      chk("rst_row",   int'(bus.cursorRow), 0);
      chk("rst_ready", int'(bus.charReady), 1);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single printable character
      push_wr(0, 0, 'h41);
      send('h41);
      chk("t1_busy_in_write",  int'(bus.busy), 1);
      chk("t1_ready_in_write", int'(bus.charReady), 0);
      @(posedge clk); #1;
      chk("t1_col",   int'(bus.cursorCol), 1);
      chk("t1_row",   int'(bus.cursorRow), 0);
      chk("t1_ready", int'(bus.charReady), 1);
      chk("t1_busy",  int'(bus.busy), 0);

      // CR back to column 0, then a full line with wrap into row 1
      send('h0D);
      busy_count(n);
      chk("t2_cr_col", int'(bus.cursorCol), 0);
      for (int i = 0; i < COLS; i++) begin
         push_wr(i, 0, 'h20 + (i % 95));
         if (i == COLS - 1) push_line(1);
         send('h20 + (i % 95));
      end
      busy_count(n);
      chk("t2_busy_cycles", n, 81);
      chk("t2_col", int'(bus.cursorCol), 0);
      chk("t2_row", int'(bus.cursorRow), 1);

      // Walk down to row 59, column 10; LF there wraps to row 0
      for (int r = 2; r < ROWS; r++) begin
         push_line(r);
         send('h0A);
      end
      for (int c = 0; c < 10; c++) begin
         push_wr(c, 59, 'h30 + c);
         send('h30 + c);
      end
      busy_count(n);
      chk("t3_col_pre", int'(bus.cursorCol), 10);
      chk("t3_row_pre", int'(bus.cursorRow), 59);
      push_line(0);
      send('h0A);
      busy_count(n);
      chk("t3_lf_busy_cycles", n, 81);
      chk("t3_col", int'(bus.cursorCol), 0);
      chk("t3_row", int'(bus.cursorRow), 0);

      // Backspace at column 0, unknown code, backspace at column 5, CR
      for (int r = 1; r <= 3; r++) begin
         push_line(r);
         send('h0A);
      end
      busy_count(n);
      send('h08);
      busy_count(n);
      chk("t4_bs0_col", int'(bus.cursorCol), 0);
      chk("t4_bs0_row", int'(bus.cursorRow), 3);
      for (int c = 0; c < 5; c++) begin
         push_wr(c, 3, 'h61 + c);
         send('h61 + c);
      end
      send('h01);
      busy_count(n);
      chk("t4_other_col", int'(bus.cursorCol), 5);
      chk("t4_other_row", int'(bus.cursorRow), 3);
      push_wr(4, 3, 'h20);
      send('h08);
      busy_count(n);
      chk("t4_bs_busy_cycles", n, 1);
      chk("t4_bs_col", int'(bus.cursorCol), 4);
      chk("t4_bs_row", int'(bus.cursorRow), 3);
      send('h0D);
      busy_count(n);
      chk("t4_cr_col", int'(bus.cursorCol), 0);
      chk("t4_cr_row", int'(bus.cursorRow), 3);

      // Form feed clears the whole screen and homes the cursor
      push_screen(ROWS * COLS);
      send('h0C);
      busy_count(n);
      chk("t5_ff_busy_cycles", n, ROWS * COLS + 1);
      chk("t5_col", int'(bus.cursorCol), 0);
      chk("t5_row", int'(bus.cursorRow), 0);

      // clearReq beats a coincident character; the char follows the clear
      push_wr(0, 0, 'h31);
      send('h31);
      push_wr(1, 0, 'h32);
      send('h32);
      busy_count(n);
      @(posedge clk); #1;
      bus.clearReq  = 1'b1;
      bus.charIn    = 7'h42;
      bus.charValid = 1'b1;
      #1;
      chk("t6_ready_blocked", int'(bus.charReady), 0);
      push_screen(ROWS * COLS);
      push_wr(0, 0, 'h42);
      @(posedge clk); #1;
      bus.clearReq = 1'b0;
      busy_count(n);
      chk("t6_clr_busy_cycles", n, ROWS * COLS);
      chk("t6_col", int'(bus.cursorCol), 0);
      chk("t6_row", int'(bus.cursorRow), 0);
      chk("t6_ready_after", int'(bus.charReady), 1);
      @(posedge clk); #1;
      bus.charValid = 1'b0;
      busy_count(n);
      chk("t6_char_col", int'(bus.cursorCol), 1);
      chk("t6_char_row", int'(bus.cursorRow), 0);

      // Reset in the middle of a full clear, right after write 1000
      push_wr(1, 0, 'h33);
      send('h33);
      busy_count(n);
      push_screen(1000);
      @(posedge clk); #1;
      bus.clearReq = 1'b1;
      @(posedge clk); #1;
      bus.clearReq = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk); #1;
         n++;
      end
      chk("t7_drained", sb.size(), 0);
      reset = 1'b1;
      #1;
      chk("t7_we_drop", int'(bus.ramWriteEn), 0);
      chk("t7_col",     int'(bus.cursorCol), 0);
      chk("t7_row",     int'(bus.cursorRow), 0);
      chk("t7_busy",    int'(bus.busy), 0);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("t7_ready", int'(bus.charReady), 1);
      repeat (30) @(posedge clk);
      #1;
      chk("end_queue_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/text_console_ctrl.md
# text_console_ctrl

Sequencing controller for the character display RAM's CPU-side port. It accepts a stream of 7-bit character codes over a valid/ready handshake and tracks an 80x60 cursor. It turns each code into glyph writes, handling control codes, line wrap and screen clears, and drives the RAM's CPU write enable, write data and glyph addresses. While `busy` is high it owns that port exclusively.

## Interface
- `RAM_WIDTH`, 7, character code width
- `RAM_ADDR_BITS`, 8, horizontal glyph address width; vertical address is `RAM_ADDR_BITS-1`
- `COLS`, 80, glyph columns, 0..COLS-1
- `ROWS`, 60, glyph rows, 0..ROWS-1
- `BLANK`, 7'h20, code written by clears and backspace

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `charIn`  in  RAM_WIDTH  character code
- `charValid`  in  1  `charIn` valid
- `charReady`  out  1  controller accepts `charIn` this cycle
- `clearReq`  in  1  full-screen clear request, sampled only in IDLE
- `busy`  out  1  state != IDLE
- `cursorCol`  out  RAM_ADDR_BITS  current column
- `cursorRow`  out  RAM_ADDR_BITS-1  current row
- `ramWriteEn`  out  1  to RAM cpuWriteEn
- `ramWriteData`  out  RAM_WIDTH  to RAM writeData
- `ramHGlyph`  out  RAM_ADDR_BITS  to RAM hGlyphCPU
- `ramVGlyph`  out  RAM_ADDR_BITS-1  to RAM vGlyphCPU

## Operation
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- `charReady = (state==IDLE) && !clearReq`. Accept = `charValid && charReady` at a rising edge.
- IDLE:
  - `clearReq` goes to CLR_ALL and takes priority; a coincident char is not accepted.
  - An accepted char is latched and the state goes to WRITE.
- WRITE lasts one cycle. The action depends on the latched code:
  - Printable 0x20-0x7E: write the code at (cursorCol, cursorRow). Then col+1; if col was COLS-1, set col=0 and advance the row.
  - 0x0A LF: no write. Set col=0 and advance the row.
  - 0x0D CR: no write. Set col=0.
  - 0x08 BS: if col>0, write BLANK at col-1 and set col=col-1. If col==0, no write and no change.
  - 0x0C FF: no write. Next state CLR_ALL.
  - Any other code: accepted, no effect.
- Row advance: row+1, or 0 when row was ROWS-1. A row advance always moves to CLR_LINE; otherwise the next state is IDLE.
- CLR_LINE: COLS consecutive write cycles. Data is BLANK, `ramVGlyph` is the new row and `ramHGlyph` runs 0..COLS-1. Then IDLE.
- CLR_ALL: ROWS*COLS write cycles in row-major order, (0,0) to (COLS-1,ROWS-1), data BLANK. After the last write, cursor goes to (0,0) and state to IDLE.
- Outside IDLE, `clearReq` is ignored and not remembered. `charValid` is held off by `charReady`=0.
- Write address packing into the RAM is {ramVGlyph, ramHGlyph}. Columns and rows never exceed COLS-1 and ROWS-1, so unused address space is never written.

## Timing
- Reset, applied asynchronously:
  - State IDLE, cursor (0,0).
  - `ramWriteEn`=0, `ramWriteData`=0, `ramHGlyph`=0, `ramVGlyph`=0, `busy`=0.
  - `charReady`=1 once `clearReq` is low.
  - Reset does not clear the screen.
- Reset mid-operation aborts immediately: `ramWriteEn` drops in the same cycle and no further writes occur.
- All RAM-side outputs and the cursor are registered.
- Char accepted at edge N:
  - WRITE occupies cycle N..N+1, with `ramWriteEn`/address/data valid in that cycle when a write applies.
  - The RAM captures at edge N+1, and the cursor updates at edge N+1.
  - Without a row advance, `charReady` is high again in the cycle after edge N+1. Sustained throughput is 1 char per 2 cycles.
- With a row advance, CLR_LINE spans COLS cycles after WRITE. `charReady` returns COLS+1 cycles after the accept edge.
- A CLR_ALL entered from IDLE via `clearReq` keeps `busy` high for exactly ROWS*COLS cycles.
- During CLR_LINE and CLR_ALL, `ramWriteEn` is continuously high; one address per cycle, no gaps.

## Test plan
- Reset, send 0x41: in the cycle after accept, `ramWriteEn`=1, H=0, V=0, data=0x41; then cursor (1,0) and `charReady`=1 two cycles after the accept edge.
- 80 printable codes from (0,0): last write at H=79,V=0; then 80 writes of 0x20 on V=1 with H 0..79; cursor (0,1); `busy` high 81 cycles.
- Cursor (10,59), send 0x0A: no WRITE-cycle write; 80 blank writes on V=0; cursor (0,0).
- BS at (0,3): no write, cursor unchanged. BS at (5,3): write 0x20 at H=4,V=3, cursor (4,3).
- `clearReq`=1 and `charValid`=1 in the same IDLE cycle: char not accepted. 4800 consecutive blank writes follow, the last at H=79,V=59. `busy` falls after exactly 4800 cycles, cursor (0,0), then the char is accepted.
- `reset` asserted during CLR_ALL at write 1000: `ramWriteEn`=0 in the same cycle, cursor (0,0); `charReady`=1 in the first cycle after deassert; no further writes.
